// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the SIPO capture stage.
package sipo_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sipo_state_e;

    localparam int SIPO_DEFAULT_WIDTH = 8;

    // The bit counter only ever holds 0 .. frame_len-1.
    function automatic int sipo_cnt_width(input int frame_len);
        return (frame_len > 2) ? $clog2(frame_len) : 1;
    endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// One-entry valid/ready holding register for assembled words; load is visible next cycle.
// blocked_o flags that an unconsumed word is held and is not being drained this edge.
module sipo_hold_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             par_err_i,
    input  logic             data_ready_i,
    output logic [WIDTH-1:0] data_out_o,
    output logic             data_valid_o,
    output logic             parity_err_o,
    output logic             blocked_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q, vld_d;
    logic             par_q, par_d;

    assign blocked_o = vld_q && !data_ready_i;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        par_d  = par_q;
        if (load_i && !blocked_o) begin
            data_d = word_i;
            par_d  = par_err_i;
            vld_d  = 1'b1;
        end else if (vld_q && data_ready_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
            par_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            par_q  <= par_d;
        end
    end

    assign data_out_o   = data_q;
    assign data_valid_o = vld_q;
    assign parity_err_o = par_q;

endmodule

// File: rtl/sipo_capture.sv
// Framed serial-to-parallel capture; word valid the cycle after its last bit, dropped (overrun) if held word not taken.
// SIPO_PARITY_EN appends an even-parity bit to every frame and reports mismatches on parity_err.
module sipo_capture
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             parity_err,
    output logic             overrun,
    output logic             frame_err
);

`ifdef SIPO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int               CNT_W    = sipo_cnt_width(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    sipo_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_LEN-2:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q;
    logic                 done;
    logic                 hold_blocked;
    logic [FRAME_LEN-1:0] frame_bits;
    logic [WIDTH-1:0]     word;
    logic                 word_par_err;

    // First bit of the frame ends up in frame_bits[FRAME_LEN-1] on the completing edge.
    assign frame_bits = {shift_q, bit_in};

    // Shifting every valid bit is harmless: stale bits are pushed out before a frame completes.
    assign shift_d = bit_valid ? frame_bits[FRAME_LEN-2:0] : shift_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_err_d = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bit_valid && frame_start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (bit_valid) begin
                    if (frame_start) begin
                        frame_err_d = 1'b1;
                        cnt_d       = CNT_W'(1);
                    end else if (cnt_q == LAST_CNT) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < WIDTH; i++) begin
            word[i] = MSB_FIRST ? frame_bits[FRAME_LEN-WIDTH+i] : frame_bits[FRAME_LEN-1-i];
        end
    end

`ifdef SIPO_PARITY_EN
    assign word_par_err = ^frame_bits;
`else
    assign word_par_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= done && hold_blocked;
        end
    end

    sipo_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk          (clk),
        .rst          (rst),
        .load_i       (done),
        .word_i       (word),
        .par_err_i    (word_par_err),
        .data_ready_i (data_ready),
        .data_out_o   (data_out),
        .data_valid_o (data_valid),
        .parity_err_o (parity_err),
        .blocked_o    (hold_blocked)
    );

    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo_capture.sv
// Self-checking bench: MSB-first and LSB-first instances driven in parallel against a queue-based model.
module tb_sipo_capture;

    localparam int W = 8;
`ifdef SIPO_PARITY_EN
    localparam int FL  = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FL  = W;
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, bit_in, bit_valid, frame_start, data_ready;
    logic [W-1:0] dout_m, dout_l;
    logic         vld_m, vld_l, perr_m, perr_l, ovr_m, ovr_l, ferr_m, ferr_l;

    always #5 clk = ~clk;

    sipo_capture #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .frame_start(frame_start),
        .data_out(dout_m), .data_valid(vld_m), .data_ready(data_ready),
        .parity_err(perr_m), .overrun(ovr_m), .frame_err(ferr_m)
    );

    sipo_capture #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .frame_start(frame_start),
        .data_out(dout_l), .data_valid(vld_l), .data_ready(data_ready),
        .parity_err(perr_l), .overrun(ovr_l), .frame_err(ferr_l)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: bits of the open frame in arrival order, plus the held word.
    logic         q_bits[$];
    logic         m_vld, m_par, m_ovr, m_ferr;
    logic [W-1:0] m_msb, m_lsb;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_bits.delete();
        m_vld  = 1'b0;
        m_msb  = '0;
        m_lsb  = '0;
        m_par  = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic model_edge(input logic bv, input logic b, input logic fs, input logic rdy);
        logic         drain, done, wp;
        logic [W-1:0] wm, wl;
        drain  = m_vld && rdy;
        done   = 1'b0;
        wm     = '0;
        wl     = '0;
        wp     = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        if (bv) begin
            if (fs) begin
                if (q_bits.size() > 0) m_ferr = 1'b1;
                q_bits.delete();
                q_bits.push_back(b);
            end else if (q_bits.size() > 0) begin
                q_bits.push_back(b);
                if (q_bits.size() == FL) begin
                    done = 1'b1;
                    for (int i = 0; i < W; i++) begin
                        wm[W-1-i] = q_bits[i];
                        wl[i]     = q_bits[i];
                    end
                    for (int i = 0; i < FL; i++) wp = wp ^ q_bits[i];
                    q_bits.delete();
                end
            end
        end
        if (done) begin
            if (!m_vld || drain) begin
                m_vld = 1'b1;
                m_msb = wm;
                m_lsb = wl;
                m_par = PAR ? wp : 1'b0;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (drain) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk1("valid_m", vld_m, m_vld);
        chk1("valid_l", vld_l, m_vld);
        chk8("data_m", dout_m, m_msb);
        chk8("data_l", dout_l, m_lsb);
        chk1("overrun_m", ovr_m, m_ovr);
        chk1("overrun_l", ovr_l, m_ovr);
        chk1("frame_err_m", ferr_m, m_ferr);
        chk1("frame_err_l", ferr_l, m_ferr);
        if (m_vld) begin
            chk1("parity_m", perr_m, m_par);
            chk1("parity_l", perr_l, m_par);
        end
    endtask

    task automatic step(input logic bv, input logic b, input logic fs, input logic rdy);
        bit_valid   = bv;
        bit_in      = b;
        frame_start = fs;
        data_ready  = rdy;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(bv, b, fs, rdy);
        #1;
        compare_all();
    endtask

    function automatic logic frame_bit(input logic [W-1:0] w, input logic p, input int i);
        if (i < W) return w[W-1-i];
        return p;
    endfunction

    task automatic send_frame(input logic [W-1:0] w, input logic p, input logic rdy, input logic rdy_last);
        for (int i = 0; i < FL; i++)
            step(1'b1, frame_bit(w, p, i), (i == 0), (i == FL - 1) ? rdy_last : rdy);
    endtask

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] exp_m;
        logic [W-1:0] exp_l;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'hAA, 8'hAA, 8'h55};
        vecs[1] = '{8'hCC, 8'hCC, 8'h33};
        vecs[2] = '{8'hF0, 8'hF0, 8'h0F};
        vecs[3] = '{8'h81, 8'h81, 8'h81};
        vecs[4] = '{8'h3C, 8'h3C, 8'h3C};
        vecs[5] = '{8'h01, 8'h01, 8'h80};
        vecs[6] = '{8'h12, 8'h12, 8'h48};
        vecs[7] = '{8'hE7, 8'hE7, 8'hE7};

        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0; data_ready = 1'b0;
        model_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk1("rst_valid", vld_m, 1'b0);
        chk8("rst_data", dout_m, 8'h00);
        chk1("rst_overrun", ovr_m, 1'b0);
        chk1("rst_frame_err", ferr_m, 1'b0);
        chk1("rst_parity", perr_m, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Single frame, consumer always ready.
        send_frame(8'hAA, ^8'hAA, 1'b1, 1'b1);
        chk1("t1_valid", vld_m, 1'b1);
        chk8("t1_data_m", dout_m, 8'hAA);
        chk8("t1_data_l", dout_l, 8'h55);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk1("t1_valid_drop", vld_m, 1'b0);

        // Second word arrives while the first is still held.
        send_frame(8'hAA, ^8'hAA, 1'b0, 1'b0);
        send_frame(8'hCC, ^8'hCC, 1'b0, 1'b0);
        chk1("t2_overrun", ovr_m, 1'b1);
        chk8("t2_data_kept", dout_m, 8'hAA);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk1("t2_overrun_pulse", ovr_m, 1'b0);
        chk1("t2_still_valid", vld_m, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk1("t2_drained", vld_m, 1'b0);

        // Completion on the same edge as the drain handshake.
        send_frame(8'hAA, ^8'hAA, 1'b0, 1'b0);
        send_frame(8'hF0, ^8'hF0, 1'b0, 1'b1);
        chk1("t3_no_overrun", ovr_m, 1'b0);
        chk1("t3_valid", vld_m, 1'b1);
        chk8("t3_data", dout_m, 8'hF0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Partial frame aborted by a new frame_start.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, frame_bit(8'h3C, ^8'h3C, 0), 1'b1, 1'b1);
        chk1("t4_frame_err", ferr_m, 1'b1);
        step(1'b1, frame_bit(8'h3C, ^8'h3C, 1), 1'b0, 1'b1);
        chk1("t4_frame_err_pulse", ferr_m, 1'b0);
        for (int i = 2; i < FL; i++) step(1'b1, frame_bit(8'h3C, ^8'h3C, i), 1'b0, 1'b1);
        chk8("t4_data", dout_m, 8'h3C);
        chk1("t4_valid", vld_m, 1'b1);

        // Asynchronous reset in the middle of a frame with a word held.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk1("t5_async_valid", vld_m, 1'b0);
        chk8("t5_async_data", dout_m, 8'h00);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < FL + 2; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        chk1("t5_idle_ignored", vld_m, 1'b0);
        send_frame(8'h81, ^8'h81, 1'b1, 1'b1);
        chk8("t5_data", dout_m, 8'h81);
        chk1("t5_no_frame_err", ferr_m, 1'b0);

`ifdef SIPO_PARITY_EN
        send_frame(8'hAA, 1'b0, 1'b1, 1'b1);
        chk1("t6_parity_ok", perr_m, 1'b0);
        send_frame(8'hAB, 1'b0, 1'b1, 1'b1);
        chk1("t6_parity_bad", perr_m, 1'b1);
        chk8("t6_parity_data", dout_m, 8'hAB);
`endif

        // Back-to-back table vectors with no dead cycles.
        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].word, ^vecs[v].word, 1'b1, 1'b1);
            chk8("tbl_data_m", dout_m, vecs[v].exp_m);
            chk8("tbl_data_l", dout_l, vecs[v].exp_l);
            chk1("tbl_valid", vld_m, 1'b1);
        end

        // Random traffic: eager consumer, then a sluggish one to provoke overruns.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 11) == 0,
                 $urandom_range(0, 3) != 0);
        end
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sipo_capture.md
# sipo_capture

Serial-in/parallel-out capture stage that sits directly downstream of the PISO shifter and rebuilds its bit stream into WIDTH-bit words. Bits are framed by a start marker and qualified by a per-bit strobe. Completed words are presented on a valid/ready output backed by a one-entry holding register. Overrun and resynchronisation faults are reported as single-cycle pulses.

## Interface
Parameters:
- WIDTH, 8, data bits per word (≥2)
- MSB_FIRST, 1, 1 = first received bit lands in data_out[WIDTH-1] (matches PISO shift order); 0 = first bit lands in data_out[0]

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- bit_in  input  1  serial data bit
- bit_valid  input  1  bit_in is sampled on this edge
- frame_start  input  1  marks bit_in as the first bit of a frame; ignored unless bit_valid=1
- data_out  output  WIDTH  assembled word; stable while data_valid=1
- data_valid  output  1  data_out holds an unconsumed word
- data_ready  input  1  consumer accepts the word on an edge where data_valid=1
- parity_err  output  1  parity check result, qualified by data_valid
- overrun  output  1  one-cycle pulse: completed word dropped
- frame_err  output  1  one-cycle pulse: partial frame aborted by a new frame_start

## Operation
- FSM states: IDLE and SHIFT. Reset state is IDLE, with bit counter = 0.
- IDLE: bit_valid && frame_start → capture bit, count = 1, go to SHIFT. bit_valid without frame_start is discarded.
- SHIFT: on bit_valid, shift bit in and increment count.
  - When count reaches FRAME_LEN (WIDTH, or WIDTH+1 with parity), the word completes. Return to IDLE with count = 0.
- frame_start && bit_valid in SHIFT → pulse frame_err, discard partial word, restart with count = 1, stay in SHIFT.
- Word completion:
  - Holding register empty, or being drained this same edge (data_valid && data_ready) → load data_out and parity_err, set data_valid.
  - Otherwise → drop the new word, keep the held word, pulse overrun.
- data_valid && data_ready with no completion that edge → clear data_valid. data_out keeps its last value.
- A single-bit frame is impossible (WIDTH≥2). Exactly one frame completes per edge at most.
- Reset values: data_out=0, data_valid=0, parity_err=0, overrun=0, frame_err=0.
- Reset mid-frame: partial word lost, no pulses, FSM in IDLE.

## Timing
- The edge that samples the final bit also loads the holding register. data_valid is high starting the cycle after that edge.
- Back-to-back frames: bit_valid may stay high continuously. frame_start may coincide with the bit immediately following the last bit of the previous frame. There are no dead cycles.
- data_ready may be held high permanently, giving zero-stall throughput.
- overrun and frame_err are registered and high for exactly one cycle after the offending edge.
- data_out is not required to change when data_valid deasserts.

## Configuration
- SIPO_PARITY_EN defined:
  - FRAME_LEN = WIDTH+1; the final bit is an even-parity bit.
  - parity_err = XOR(data bits, parity bit). It is registered together with data_out and is meaningful only while data_valid=1.
  - The word is delivered even when parity fails.
- SIPO_PARITY_EN undefined:
  - FRAME_LEN = WIDTH.
  - parity_err is tied to 0; the port remains present so the interface is identical in both builds.

## Structure
- sipo_pkg holds:
  - the state enum (ST_IDLE, ST_SHIFT)
  - the default WIDTH constant
  - a function computing counter width from FRAME_LEN
- One sub-module is natural: sipo_hold_reg.
  - It is the one-entry valid/ready holding register.
  - Inputs: load, word, parity flag, data_ready.
  - Outputs: data_out, data_valid, parity_err, and an accept-blocked indication that drives overrun.
- The top level contains the FSM, bit counter and shift register.

## Test plan
- Reset, then a frame of 10101010 MSB-first with data_ready=1 → data_valid pulses one cycle with data_out=8'hAA, no error pulses.
- Two back-to-back frames 8'hAA then 8'hCC, data_ready held 0 until after the second completes → data_out=8'hAA retained, overrun pulses once; after a ready handshake data_valid=0.
- Frame 8'hF0 with completion on the same edge as the previous word's data_ready handshake → no overrun, data_out=8'hF0.
- Four bits of a frame, then frame_start with a new frame 8'h3C → frame_err pulses once, data_out=8'h3C.
- rst asserted after five bits of a frame, then a full frame 8'h81 → outputs go to zero during reset, data_out=8'h81 afterwards, no error pulses; bits without frame_start in IDLE are ignored.
- SIPO_PARITY_EN with 8'hAA + parity 0 → parity_err=0; with 8'hAB + parity 0 → parity_err=1 and data_out=8'hAB. MSB_FIRST=0 with 8'hAA sent MSB-first → data_out=8'h55.
